// File: rtl/kernel_bc_write_back_burst.sv
// rtl/kernel_bc_write_back_burst.sv - BC kernel write-back stage: drains result FIFO into 4 KB-safe AXI write bursts
module kernel_bc_write_back_burst #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_BURST  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start_empty_n,
  output logic                  start_read,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [31:0]           num_items,
  input  logic                  res_empty_n,
  input  logic [DATA_WIDTH-1:0] res_dout,
  output logic                  res_read,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [ADDR_WIDTH-1:0] m_awaddr,
  output logic [7:0]            m_awlen,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  output logic [DATA_WIDTH-1:0] m_wdata,
  output logic                  m_wlast,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  input  logic [1:0]            m_bresp,
  output logic                  done,
  output logic                  idle,
  output logic                  err
);
  localparam int BPW   = DATA_WIDTH / 8;
  localparam int ALIGN = $clog2(BPW);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(BPW - 1));

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_DONE} state_t;
  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           remaining_q;
  logic [7:0]            beat_q;
  logic [7:0]            burst_len_q;
  logic                  err_q;

  // Burst length is the tightest of: words left, MAX_BURST, words to the next 4 KB page.
  logic [12:0] page_bytes;
  logic [31:0] page_words;
  logic [31:0] burst_words;
  logic [7:0]  awlen_calc;
  always_comb begin
    page_bytes  = 13'd4096 - {1'b0, addr_q[11:0]};
    page_words  = 32'(page_bytes >> ALIGN);
    burst_words = remaining_q;
    if (burst_words > 32'(MAX_BURST)) burst_words = 32'(MAX_BURST);
    if (burst_words > page_words) burst_words = page_words;
    awlen_calc  = 8'(burst_words - 32'd1);
  end

  logic last_beat;
  logic w_fire;
  assign last_beat = (beat_q == burst_len_q);
  assign w_fire    = (state_q == S_W) && res_empty_n && m_wready;

  always_comb begin
    state_d    = state_q;
    start_read = 1'b0;
    m_awvalid  = 1'b0;
    m_wvalid   = 1'b0;
    m_wlast    = 1'b0;
    res_read   = 1'b0;
    m_bready   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_empty_n) begin
          start_read = 1'b1;
          state_d    = (num_items == 32'd0) ? S_DONE : S_AW;
        end
      end
      S_AW: begin
        m_awvalid = 1'b1;
        if (m_awready) state_d = S_W;
      end
      S_W: begin
        m_wvalid = res_empty_n;
        res_read = res_empty_n && m_wready;
        m_wlast  = last_beat;
        if (w_fire && last_beat) state_d = S_B;
      end
      S_B: begin
        m_bready = 1'b1;
        if (m_bvalid) state_d = (remaining_q == 32'd0) ? S_DONE : S_AW;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q      <= '0;
      remaining_q <= '0;
      beat_q      <= '0;
      burst_len_q <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_empty_n) begin
            addr_q      <= base_addr & ALIGN_MASK;
            remaining_q <= num_items;
            err_q       <= 1'b0;
          end
        end
        S_AW: begin
          if (m_awready) begin
            beat_q      <= '0;
            burst_len_q <= awlen_calc;
          end
        end
        S_W: begin
          if (w_fire) begin
            beat_q      <= beat_q + 8'd1;
            addr_q      <= addr_q + ADDR_WIDTH'(BPW);
            remaining_q <= remaining_q - 32'd1;
          end
        end
        S_B: begin
          if (m_bvalid && (m_bresp != 2'b00)) err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // While AW is pending the length is live from addr/remaining, which are frozen in that state.
  assign m_awaddr = addr_q;
  assign m_awlen  = (state_q == S_AW) ? awlen_calc : burst_len_q;
  assign m_wdata  = res_dout;
  assign done     = (state_q == S_DONE);
  assign idle     = (state_q == S_IDLE);
  assign err      = err_q;
endmodule

// File: tb/tb_kernel_bc_write_back_burst.sv
// tb/tb_kernel_bc_write_back_burst.sv - self-checking bench for kernel_bc_write_back_burst
module tb_kernel_bc_write_back_burst;
  localparam int MAXB = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start_empty_n, start_read;
  logic [31:0] base_addr, num_items;
  logic        res_empty_n, res_read;
  logic [31:0] res_dout;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_wlast;
  logic [31:0] m_awaddr, m_wdata;
  logic [7:0]  m_awlen;
  logic        m_bvalid, m_bready;
  logic [1:0]  m_bresp;
  logic        done, idle, err;

  kernel_bc_write_back_burst #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_BURST(MAXB)) dut (
    .clk(clk), .reset_n(reset_n), .start_empty_n(start_empty_n), .start_read(start_read),
    .base_addr(base_addr), .num_items(num_items), .res_empty_n(res_empty_n), .res_dout(res_dout),
    .res_read(res_read), .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_awlen(m_awlen), .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata),
    .m_wlast(m_wlast), .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .done(done), .idle(idle), .err(err));

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory-side view of the job: result FIFO contents, expected words and expected bursts.
  logic [31:0] fifo[$];
  logic [31:0] exp_data[$];
  logic [31:0] exp_aw_addr[$];
  logic [7:0]  exp_aw_len[$];
  logic [31:0] aw_log_addr[$];
  logic [7:0]  aw_log_len[$];

  bit   job_active, done_owed, aw_owed, burst_open, resp_owed, job_err;
  bit   pop_pending, tok_popped;
  int   beat, cur_len, jobs_done, total_beats;
  bit   rnd;
  logic [1:0] bresp_val;
  int   tokens_left;

  function automatic void plan(input logic [31:0] base, input int unsigned n);
    logic [31:0] a;
    int unsigned rem, len, room;
    a   = base & 32'hFFFF_FFFC;
    rem = n;
    while (rem > 0) begin
      room = (4096 - int'(a % 4096)) / 4;
      len  = rem;
      if (len > MAXB) len = MAXB;
      if (len > room) len = room;
      exp_aw_addr.push_back(a);
      exp_aw_len.push_back(8'(len - 1));
      a   = a + 32'(len * 4);
      rem = rem - len;
    end
  endfunction

  always @(negedge clk) begin
    if (!reset_n) begin
      job_active = 0; done_owed = 0; aw_owed = 0; burst_open = 0; resp_owed = 0; job_err = 0;
      pop_pending = 0; tok_popped = 0;
      exp_data.delete(); exp_aw_addr.delete(); exp_aw_len.delete();
    end else begin
      chk("idle", idle, !job_active);
      chk("start_read", start_read, !job_active && start_empty_n);
      chk("done", done, done_owed);
      chk("err", err, job_err);
      chk("awvalid", m_awvalid, aw_owed);
      chk("bready", m_bready, resp_owed);
      chk("wvalid", m_wvalid, burst_open && res_empty_n);
      chk("res_read", res_read, burst_open && res_empty_n && m_wready);
      if (aw_owed && exp_aw_addr.size() > 0) begin
        chk("awaddr", m_awaddr, exp_aw_addr[0]);
        chk("awlen", m_awlen, exp_aw_len[0]);
      end
      if (burst_open && m_wvalid) chk("wlast", m_wlast, beat == cur_len);

      if (done_owed) begin
        done_owed = 0; job_active = 0; jobs_done++;
      end
      if (start_read) begin
        job_active = 1; job_err = 0; tok_popped = 1;
        plan(base_addr, num_items);
        if (num_items == 0) done_owed = 1; else aw_owed = 1;
      end else if (aw_owed && m_awready) begin
        aw_log_addr.push_back(m_awaddr);
        aw_log_len.push_back(m_awlen);
        cur_len = (exp_aw_len.size() > 0) ? int'(exp_aw_len[0]) : 0;
        void'(exp_aw_addr.pop_front());
        void'(exp_aw_len.pop_front());
        aw_owed = 0; burst_open = 1; beat = 0;
      end else if (burst_open && res_read) begin
        chk("wdata", m_wdata, (exp_data.size() > 0) ? exp_data[0] : 32'hDEAD_BEEF);
        void'(exp_data.pop_front());
        pop_pending = 1;
        total_beats++;
        if (beat == cur_len) begin
          burst_open = 0; resp_owed = 1;
        end
        beat++;
      end else if (resp_owed && m_bvalid) begin
        if (m_bresp != 2'b00) job_err = 1;
        resp_owed = 0;
        if (exp_aw_addr.size() == 0) done_owed = 1; else aw_owed = 1;
      end
    end
  end

  task automatic cycle();
    @(posedge clk); #1;
    if (pop_pending) begin
      void'(fifo.pop_front());
      pop_pending = 0;
    end
    if (tok_popped) begin
      tokens_left--;
      tok_popped = 0;
    end
    start_empty_n = (tokens_left > 0);
    res_empty_n   = (fifo.size() > 0) && (!rnd || $urandom_range(3) != 0);
    res_dout      = (fifo.size() > 0) ? fifo[0] : 32'h0;
    m_awready     = !rnd || ($urandom_range(1) != 0);
    m_wready      = !rnd || ($urandom_range(3) != 0);
    m_bvalid      = resp_owed && (!rnd || $urandom_range(2) == 0);
    m_bresp       = bresp_val;
  endtask

  task automatic run_job(input logic [31:0] base, input int n, input bit r, input logic [1:0] br,
                         input int reps);
    int target;
    cycle();
    rnd = r; bresp_val = br;
    aw_log_addr.delete(); aw_log_len.delete();
    for (int i = 0; i < n * reps; i++) begin
      logic [31:0] w;
      w = $urandom;
      fifo.push_back(w);
      exp_data.push_back(w);
    end
    base_addr = base; num_items = 32'(n);
    tokens_left = reps;
    start_empty_n = 1'b1;
    target = jobs_done + reps;
    for (int c = 0; c < 3000 && jobs_done < target; c++) cycle();
    vectors++;
    if (jobs_done < target) begin
      miscompares++;
      $display("FAIL job_timeout: base 0x%0h completed %0d of %0d jobs", base, jobs_done, target);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_start_read", start_read, 0);
    chk("rst_res_read", res_read, 0);
    chk("rst_awvalid", m_awvalid, 0);
    chk("rst_wvalid", m_wvalid, 0);
    chk("rst_wlast", m_wlast, 0);
    chk("rst_bready", m_bready, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_idle", idle, 1);
    chk("rst_awaddr", m_awaddr, 0);
    chk("rst_awlen", m_awlen, 0);
  endtask

  initial begin
    reset_n = 0; start_empty_n = 0; base_addr = 0; num_items = 0; res_empty_n = 0; res_dout = 0;
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0; rnd = 0; bresp_val = 0; tokens_left = 0;
    jobs_done = 0; total_beats = 0;
    repeat (3) @(posedge clk);
    #1 chk_reset_outputs();
    reset_n = 1;

    run_job(32'h1000, 5, 0, 2'b00, 1);
    chk("basic_nbursts", aw_log_addr.size(), 1);
    chk("basic_awaddr", aw_log_addr[0], 32'h1000);
    chk("basic_awlen", aw_log_len[0], 4);
    chk("basic_err", err, 0);

    run_job(32'h0, 40, 0, 2'b00, 1);
    chk("long_nbursts", aw_log_addr.size(), 3);
    chk("long_aw0", {aw_log_addr[0][23:0], aw_log_len[0]}, {24'h0, 8'd15});
    chk("long_aw1", {aw_log_addr[1][23:0], aw_log_len[1]}, {24'h40, 8'd15});
    chk("long_aw2", {aw_log_addr[2][23:0], aw_log_len[2]}, {24'h80, 8'd7});

    run_job(32'h0FF8, 4, 0, 2'b00, 1);
    chk("split_nbursts", aw_log_addr.size(), 2);
    chk("split_aw0", {aw_log_addr[0][23:0], aw_log_len[0]}, {24'hFF8, 8'd1});
    chk("split_aw1", {aw_log_addr[1][23:0], aw_log_len[1]}, {24'h1000, 8'd1});

    run_job(32'h2000, 0, 0, 2'b00, 1);
    chk("zero_nbursts", aw_log_addr.size(), 0);

    run_job(32'h3000, 3, 0, 2'b10, 1);
    chk("errjob_err", err, 1);
    run_job(32'h3000, 2, 0, 2'b00, 1);
    chk("clear_err", err, 0);

    run_job(32'h1003, 2, 0, 2'b00, 1);
    chk("align_awaddr", aw_log_addr[0], 32'h1000);

    run_job(32'hFFFF_FFF8, 4, 0, 2'b00, 1);
    chk("wrap_aw0", aw_log_addr[0], 32'hFFFF_FFF8);
    chk("wrap_aw1", aw_log_addr[1], 32'h0);

    run_job(32'h4000, 3, 0, 2'b00, 2);
    chk("b2b_nbursts", aw_log_addr.size(), 2);

    for (int j = 0; j < 10; j++) begin
      logic [31:0] b;
      b = (32'($urandom_range(0, 3)) << 12) | 32'(4096 - 4 * $urandom_range(1, 24));
      run_job(b, $urandom_range(1, 45), 1, (j == 4) ? 2'b01 : 2'b00, 1 + (j % 2));
    end

    // Abandon a burst while beat 3 is pending, then restart cleanly.
    begin
      int b0;
      cycle();
      rnd = 0; bresp_val = 0;
      for (int i = 0; i < 8; i++) begin
        fifo.push_back(32'hA000 + 32'(i));
        exp_data.push_back(32'hA000 + 32'(i));
      end
      base_addr = 32'h5000; num_items = 8; tokens_left = 1; start_empty_n = 1;
      b0 = total_beats;
      for (int c = 0; c < 50 && total_beats - b0 < 2; c++) cycle();
      #2 reset_n = 0;
      #1 chk_reset_outputs();
      fifo.delete(); tokens_left = 0; start_empty_n = 0; m_bvalid = 0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1;
    end
    run_job(32'h6000, 6, 0, 2'b00, 1);
    chk("restart_awaddr", aw_log_addr[0], 32'h6000);
    chk("restart_awlen", aw_log_len[0], 5);

    repeat (3) cycle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
